// File: rtl/aes_arbiter.sv
// aes_arbiter: round-robin sharing of one aes_core between NREQ requesters; optional run timeout via AES_ARB_TIMEOUT_EN
module aes_arbiter #(
    parameter int NREQ        = 2,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*128-1:0]   req_key_i,
    input  logic [NREQ*128-1:0]   req_text_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    input  logic [NREQ-1:0]       rsp_ready_i,
    output logic [127:0]          rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  core_load_o,
    output logic [127:0]          core_key_o,
    output logic [127:0]          core_plaintext_o,
    input  logic                  core_done_i,
    input  logic [127:0]          core_cyphertext_i
);
    localparam int IW = $clog2(NREQ);
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    if (NREQ < 2 || NREQ > 4 || LOAD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("aes_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, g_q, g_d, gnt;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [127:0]    key_q, key_d, text_q, text_d, data_q, data_d;
    logic            found;
    int              j;
`ifdef AES_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            err_q, err_d;
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign busy_o           = state_q != IDLE;
    assign core_load_o      = state_q != RUN;
    assign core_key_o       = key_q;
    assign core_plaintext_o = text_q;
    assign rsp_data_o       = data_q;
    assign rsp_valid_o      = (state_q == RESP) ? (NREQ'(1) << g_q) : '0;

    // first valid requester at or after the round-robin pointer, wrapping
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j -= NREQ;
            if (!found && req_valid_i[IW'(j)]) begin
                found = 1'b1;
                gnt   = IW'(j);
            end
        end
    end

    // next-state logic: grant, load countdown, run until done, hold response
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        text_d      = text_q;
        data_d      = data_q;
        req_ready_o = '0;
`ifdef AES_ARB_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: if (found && reset_n_i) begin
                req_ready_o[gnt] = 1'b1;
                key_d   = req_key_i[{gnt, 7'd0} +: 128];
                text_d  = req_text_i[{gnt, 7'd0} +: 128];
                g_d     = gnt;
                cnt_d   = LW'(LOAD_CYCLES - 1);
                state_d = LOAD;
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
`ifdef AES_ARB_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (core_done_i) begin
                    data_d  = core_cyphertext_i;
                    state_d = RESP;
`ifdef AES_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
`endif
                end
            end
            RESP: if (rsp_ready_i[g_q]) begin
                rr_d    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared by async reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            text_q  <= '0;
            data_q  <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            tcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            text_q  <= text_d;
            data_q  <= data_d;
`ifdef AES_ARB_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: doc/aes_arbiter.md
Name: aes_arbiter

Overview:
- Sequences `aes_core` and shares it between NREQ requesters (SPI front end, on-chip test engine, future DMA).
- Accepts key/plaintext jobs over a valid/ready handshake and grants the core round-robin.
- Drives `load` and holds operands stable for the whole encryption, captures `cyphertext` on `done`, and returns the result to the granted requester.
- Only one job is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LOAD_CYCLES, 2, cycles `core_load` stays high after operand capture (>=1).
- TIMEOUT, 64, max RUN cycles before error abort (used only with the optional feature).

Ports:
- clk  in  1  system clock (core clock domain)
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  job request, one bit per requester
- req_ready  out  NREQ  one-hot accept pulse
- req_key  in  NREQ*128  key for requester i at [128*i +: 128]
- req_text  in  NREQ*128  plaintext for requester i at [128*i +: 128]
- rsp_valid  out  NREQ  one-hot result valid
- rsp_ready  in  NREQ  result accept, per requester
- rsp_data  out  128  cyphertext of the current response
- rsp_err  out  1  response is an aborted job (timeout)
- busy  out  1  high in every state except IDLE
- core_load  out  1  to `aes_core` load
- core_key  out  128  to `aes_core` key
- core_plaintext  out  128  to `aes_core` plaintext
- core_done  in  1  from `aes_core` done
- core_cyphertext  in  128  from `aes_core` cyphertext

Behaviour:
- Reset (async, any state):
  - state=IDLE, core_load=1, req_ready=0, rsp_valid=0, rsp_err=0.
  - rsp_data=0, core_key=0, core_plaintext=0.
  - rr pointer=0, counters=0.
  - An in-flight job is discarded with no response.
- IDLE:
  - core_load=1, which holds the core cleared.
  - If any req_valid, grant the first valid index at or after the rr pointer, wrapping modulo NREQ.
  - On grant: req_ready[g]=1 for exactly that cycle; capture req_key[g]/req_text[g] into core_key/core_plaintext; latch g; go to LOAD.
  - req_ready is registered-combinational from IDLE only; it is 0 in all other states.
- LOAD:
  - core_load=1 for LOAD_CYCLES cycles (down-counter), then go to RUN.
  - This also clears any stale `done` left high by the previous job.
- RUN:
  - core_load=0.
  - core_key/core_plaintext are held constant until the state leaves RUN. The core samples the key on its first cycle and plaintext through its fourth.
  - The core asserts `done` nominally 44 cycles after load falls (11 rounds x 4 cycles).
  - On the first cycle core_done=1: rsp_data<=core_cyphertext, rsp_err<=0, go to RESP.
- RESP:
  - rsp_valid[g]=1; rsp_data/rsp_err are stable while rsp_valid is high.
  - When rsp_ready[g]=1: rsp_valid<=0, rr pointer<=(g+1) mod NREQ, go to IDLE, core_load=1.
  - rsp_ready of non-granted indices is ignored.
- Latency:
  - Grant at cycle T; RUN begins at T+LOAD_CYCLES+1.
  - rsp_valid rises the cycle after core_done is sampled high.
  - Default total is 47 cycles.
- Fairness: a requester that is not granted keeps req_valid high. A requester just served has lowest priority next grant.
- Simultaneous events:
  - req_valid arriving during LOAD/RUN/RESP waits, with no accept.
  - The same requester may re-request while its response is pending; the request is granted only after returning to IDLE.
  - A req_valid drop before grant is legal and means no grant.
- core_done high in LOAD is ignored (stale).

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- Defined:
  - RUN counts cycles from entry.
  - If the count reaches TIMEOUT with no core_done: rsp_data<=0, rsp_err<=1, go to RESP, core_load<=1.
  - The rr pointer advances normally after the response.
- Undefined:
  - No counter; RUN waits indefinitely.
  - rsp_err is tied 0.

Test Plan:
- FIPS-197 single job:
  - Stimulus: req 0 with key 2b7e151628aed2a6abf7158809cf4f3c and text 3243f6a8885a308d313198a2e0370734.
  - Required response: rsp_valid[0] at T+47 with rsp_data 3925841d02dc09fbdc118597196a0b32, rsp_err=0.
- Round-robin:
  - Stimulus: req_valid=2'b11 held continuously, rsp_ready=1.
  - Required response: grants alternate 0,1,0,1, each result correct for its own key/text, and no requester is granted twice in a row.
- Backpressure:
  - Stimulus: rsp_ready[0]=0 for 20 cycles after rsp_valid.
  - Required response: rsp_valid/rsp_data hold stable, busy=1, req 1 is not accepted until after release.
- Operand stability:
  - Stimulus: change req_key/req_text of the granted requester during RUN.
  - Required response: core_key/core_plaintext are unchanged and the result matches the originally captured operands.
- Timeout (AES_ARB_TIMEOUT_EN):
  - Stimulus: core_done tied 0.
  - Required response: rsp_valid at RUN entry+64+1 with rsp_err=1 and rsp_data=0; without the macro, the arbiter stays in RUN.
- Reset mid-RUN:
  - Stimulus: pulse reset_n low at cycle 20 of RUN.
  - Required response: core_load=1 and rsp_valid=0 immediately; after release, a new FIPS job completes correctly with pointer 0.
